npc_select_control: RTL and testbench
=====================================

NPC_SELECT_CONTROL -- requirements
Module: npc_select_control

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'd0, the PC value loaded while reset is asserted.
REQ-002 SHALL provide parameter RESET_NPC, default 32'd4, the nPC value loaded while reset is asserted.
REQ-003 SHALL provide parameter TRAP_VECTOR, default 32'h0000_0080, the trap handler entry address.
REQ-004 Clk  input  1  single clock; all state updates on rising edge.
REQ-005 Reset  input  1  synchronous, active-low reset (0 = reset), sampled on rising Clk.
REQ-006 PC  input  32  current PC register output.
REQ-007 nPC  input  32  current nPC register output.
REQ-008 stall  input  1  hazard-unit hold request; 1 = freeze fetch.
REQ-009 br_valid  input  1  control-transfer instruction resolved in ID this cycle.
REQ-010 br_taken  input  1  resolved condition; 1 = taken; meaningful only when br_valid=1.
REQ-011 br_uncond  input  1  branch-always/jump; meaningful only when br_valid=1.
REQ-012 annul  input  1  annul bit of the resolved instruction.
REQ-013 br_target  input  32  resolved target address.
REQ-014 trap_req  input  1  trap request; highest priority.
REQ-015 PC_DS  output  32  next value for the PC register.
REQ-016 nPC_DS  output  32  next value for the nPC register.
REQ-017 PC_LE  output  1  PC register load enable.
REQ-018 nPC_LE  output  1  nPC register load enable.
REQ-019 squash_IF  output  1  kills the instruction entering IF/ID on the next edge.
REQ-020 in_dslot  output  1  the instruction now being fetched is a live delay slot.
REQ-021 dcti_err  output  1  sticky flag: control transfer resolved inside a delay slot.

Function
REQ-022 SHALL implement a registered 2-bit FSM with states SEQ, DSLOT, ANNUL, TRAP; PC_DS, nPC_DS, PC_LE, nPC_LE and squash_IF are combinational from inputs and state; in_dslot = (state==DSLOT).
REQ-023 Priority per cycle: reset > trap_req > stall > br_valid > sequential.
REQ-024 Sequential (no event): PC_DS=nPC, nPC_DS=nPC+4 modulo 2^32 (32'hFFFF_FFFC wraps to 0), both LE=1, squash_IF=0, next state SEQ.
REQ-025 trap_req=1 (even while stall=1): PC_DS=TRAP_VECTOR, nPC_DS=TRAP_VECTOR+4, both LE=1, squash_IF=1, next state TRAP.
REQ-026 stall=1 with no trap: PC_LE=nPC_LE=0, squash_IF=0, state held, branch inputs ignored (the hazard unit re-presents them).
REQ-027 Taken, non-annulled (br_taken=1, annul=0): PC_DS=nPC, nPC_DS=br_target, squash_IF=0, next state DSLOT.
REQ-028 Taken conditional with annul=1: same as REQ-027 (delay slot executes).
REQ-029 Unconditional with annul=1: PC_DS=br_target, nPC_DS=br_target+4, squash_IF=1, next state ANNUL.
REQ-030 Not taken with annul=1: sequential update (REQ-024) plus squash_IF=1, next state ANNUL.
REQ-031 Not taken with annul=0: sequential update, next state SEQ.
REQ-032 DSLOT, ANNUL and TRAP last exactly one unstalled cycle and then return to SEQ unless a new event occurs.
REQ-033 br_valid=1 in DSLOT state: transfer ignored, sequential update, dcti_err set to 1 and held until reset.
REQ-034 br_valid=1 in ANNUL or TRAP state: ignored (the instruction is squashed), dcti_err unchanged.

Reset
REQ-035 While Reset=0 at a rising edge: state becomes SEQ and dcti_err becomes 0.
REQ-036 While Reset=0 (combinational outputs): PC_DS=RESET_PC, nPC_DS=RESET_NPC, PC_LE=nPC_LE=1, squash_IF=1, regardless of all other inputs.
REQ-037 Reset mid-operation (any state, stall or pending trap) SHALL discard all pending events; the first cycle after release behaves as SEQ.

Verification
REQ-038 Reset=0 for 2 cycles, then release with PC=0, nPC=4 -> during reset PC_DS=0, nPC_DS=4, squash_IF=1; after release PC_DS=4, nPC_DS=8.
REQ-039 nPC=0x100, br_valid=1, br_taken=1, annul=0, br_target=0x400 -> PC_DS=0x100, nPC_DS=0x400, next cycle in_dslot=1.
REQ-040 nPC=0x200, br_valid=1, br_taken=0, annul=1 -> PC_DS=0x200, nPC_DS=0x204, squash_IF=1, state ANNUL for one cycle.
REQ-041 stall=1 and trap_req=1 with nPC=0x300 -> PC_DS=0x80, nPC_DS=0x84, both LE=1, squash_IF=1; stall=1 alone -> both LE=0.
REQ-042 In DSLOT state, br_valid=1 and br_taken=1 -> sequential update, dcti_err=1 persisting until Reset=0.
REQ-043 nPC=0xFFFF_FFFC with no event -> nPC_DS=0x0000_0000.

Source files
------------

// File: rtl/npc_select_control.sv
// npc_select_control: next-PC / next-nPC selection for a delayed-branch fetch unit.
// Chooses the values and load enables for the PC and nPC registers each cycle.
// A small state machine remembers whether the instruction now being fetched is
// a live delay slot, an annulled slot or the first trap-handler fetch.
//
// Ports
//   Clk          clock, all state on rising edge
//   Reset        synchronous active-low reset
//   PC, nPC      current PC / nPC register values
//   stall        hold request from the hazard unit
//   br_valid     control transfer resolved in ID this cycle
//   br_taken     resolved condition (taken)
//   br_uncond    branch-always / jump
//   annul        annul bit of the resolved instruction
//   br_target    resolved target address
//   trap_req     trap request, highest priority after reset
//   PC_DS        next value for PC          (combinational)
//   nPC_DS       next value for nPC         (combinational)
//   PC_LE        PC load enable             (combinational)
//   nPC_LE       nPC load enable            (combinational)
//   squash_IF    kill instruction entering IF/ID (combinational)
//   in_dslot     fetch is a live delay slot (decoded from state register)
//   dcti_err     sticky: transfer resolved inside a delay slot (registered)
module npc_select_control #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter logic [31:0] RESET_NPC   = 32'd4,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0080
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PC,
  input  logic [31:0] nPC,
  input  logic        stall,
  input  logic        br_valid,
  input  logic        br_taken,
  input  logic        br_uncond,
  input  logic        annul,
  input  logic [31:0] br_target,
  input  logic        trap_req,
  output logic [31:0] PC_DS,
  output logic [31:0] nPC_DS,
  output logic        PC_LE,
  output logic        nPC_LE,
  output logic        squash_IF,
  output logic        in_dslot,
  output logic        dcti_err
);

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned INSN_SZ  = 4;

  typedef enum logic [1:0] {
    SEQ   = 2'd0,
    DSLOT = 2'd1,
    ANNUL = 2'd2,
    TRAP  = 2'd3
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   dcti_err_nxt;

  // Sequential successor addresses; nPC+4 wraps modulo 2^32.
  logic [ADDR_W-1:0] seq_npc;
  logic [ADDR_W-1:0] tgt_npc;
  logic [ADDR_W-1:0] trap_npc;

  assign seq_npc  = ADDR_W'(nPC + ADDR_W'(INSN_SZ));
  assign tgt_npc  = ADDR_W'(br_target + ADDR_W'(INSN_SZ));
  assign trap_npc = ADDR_W'(TRAP_VECTOR + ADDR_W'(INSN_SZ));

  // PC is part of the register interface but the next-address choice only
  // depends on nPC in a delayed-branch machine.
  logic pc_unused;
  assign pc_unused = ^PC;

  // Branch classification: an unconditional transfer is always taken.
  logic br_is_taken;
  logic br_uncond_annul;
  assign br_is_taken     = br_taken | br_uncond;
  assign br_uncond_annul = br_uncond & annul;

  // State register and sticky error flag.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= SEQ;
      dcti_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      dcti_err <= dcti_err_nxt | pc_unused & 1'b0;
    end
  end

  // Next-state and next-address selection: reset > trap > stall > branch > seq.
  always_comb begin
    PC_DS        = nPC;
    nPC_DS       = seq_npc;
    PC_LE        = 1'b1;
    nPC_LE       = 1'b1;
    squash_IF    = 1'b0;
    state_nxt    = SEQ;
    dcti_err_nxt = dcti_err;

    if (!Reset) begin
      PC_DS        = RESET_PC;
      nPC_DS       = RESET_NPC;
      squash_IF    = 1'b1;
      dcti_err_nxt = 1'b0;
    end else if (trap_req) begin
      PC_DS     = TRAP_VECTOR;
      nPC_DS    = trap_npc;
      squash_IF = 1'b1;
      state_nxt = TRAP;
    end else if (stall) begin
      // Hold everything; the hazard unit re-presents the branch later.
      PC_LE     = 1'b0;
      nPC_LE    = 1'b0;
      state_nxt = state;
    end else if (br_valid) begin
      unique case (state)
        SEQ: begin
          if (br_uncond_annul) begin
            // Annulled always-branch: skip the slot, fetch target directly.
            PC_DS     = br_target;
            nPC_DS    = tgt_npc;
            squash_IF = 1'b1;
            state_nxt = ANNUL;
          end else if (br_is_taken) begin
            // Slot at nPC executes, then the target.
            nPC_DS    = br_target;
            state_nxt = DSLOT;
          end else if (annul) begin
            // Untaken annulled branch kills its delay slot.
            squash_IF = 1'b1;
            state_nxt = ANNUL;
          end else begin
            state_nxt = SEQ;
          end
        end
        DSLOT: begin
          // Transfer inside a delay slot is unsupported: flag and ignore.
          dcti_err_nxt = 1'b1;
        end
        default: begin
          // Instruction is squashed; its transfer has no effect.
          state_nxt = SEQ;
        end
      endcase
    end
  end

  assign in_dslot = (state == DSLOT);

endmodule

// File: tb/tb_npc_select_control.sv
// Directed bench for npc_select_control: each vector is applied on the falling
// edge, combinational outputs are compared 1 ns later, and state-derived
// outputs are compared in the cycle after the event that set them.
module tb_npc_select_control;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PC;
  logic [31:0] nPC;
  logic        stall;
  logic        br_valid;
  logic        br_taken;
  logic        br_uncond;
  logic        annul;
  logic [31:0] br_target;
  logic        trap_req;
  logic [31:0] PC_DS;
  logic [31:0] nPC_DS;
  logic        PC_LE;
  logic        nPC_LE;
  logic        squash_IF;
  logic        in_dslot;
  logic        dcti_err;

  int errors = 0;
  int checks = 0;

  always #5 Clk = ~Clk;

  npc_select_control dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .PC        (PC),
    .nPC       (nPC),
    .stall     (stall),
    .br_valid  (br_valid),
    .br_taken  (br_taken),
    .br_uncond (br_uncond),
    .annul     (annul),
    .br_target (br_target),
    .trap_req  (trap_req),
    .PC_DS     (PC_DS),
    .nPC_DS    (nPC_DS),
    .PC_LE     (PC_LE),
    .nPC_LE    (nPC_LE),
    .squash_IF (squash_IF),
    .in_dslot  (in_dslot),
    .dcti_err  (dcti_err)
  );

  // Single comparison point.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Apply one vector on the falling edge and let combinational outputs settle.
  task automatic drive(input logic rst, input logic stl, input logic trp,
                       input logic bv, input logic bt, input logic bu, input logic an,
                       input logic [31:0] npc, input logic [31:0] tgt);
    @(negedge Clk);
    Reset     = rst;
    stall     = stl;
    trap_req  = trp;
    br_valid  = bv;
    br_taken  = bt;
    br_uncond = bu;
    annul     = an;
    nPC       = npc;
    PC        = npc - 32'd4;
    br_target = tgt;
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] pc, input logic [31:0] npc,
                            input logic le, input logic sq);
    check({tag, ".PC_DS"}, PC_DS, pc);
    check({tag, ".nPC_DS"}, nPC_DS, npc);
    check({tag, ".PC_LE"}, 32'(PC_LE), 32'(le));
    check({tag, ".nPC_LE"}, 32'(nPC_LE), 32'(le));
    check({tag, ".squash"}, 32'(squash_IF), 32'(sq));
  endtask

  initial begin
    Reset = 1'b0; stall = 1'b0; trap_req = 1'b0; br_valid = 1'b0; br_taken = 1'b0;
    br_uncond = 1'b0; annul = 1'b0; nPC = 32'd4; PC = 32'd0; br_target = 32'd0;

    // Reset overrides every other input.
    drive(0, 1, 1, 1, 1, 1, 1, 32'h0000_1234, 32'h0000_5678);
    expect_out("rst_busy", 32'h0, 32'h4, 1'b1, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 32'd4, 32'd0);
    expect_out("rst_idle", 32'h0, 32'h4, 1'b1, 1'b1);
    check("rst.in_dslot", 32'(in_dslot), 32'd0);
    check("rst.dcti_err", 32'(dcti_err), 32'd0);

    // Release: plain sequential fetch.
    drive(1, 0, 0, 0, 0, 0, 0, 32'd4, 32'd0);
    expect_out("seq", 32'h4, 32'h8, 1'b1, 1'b0);

    // Taken, not annulled -> delay slot.
    drive(1, 0, 0, 1, 1, 0, 0, 32'h100, 32'h400);
    expect_out("taken", 32'h100, 32'h400, 1'b1, 1'b0);

    // Transfer inside the delay slot is ignored and flagged.
    drive(1, 0, 0, 1, 1, 0, 0, 32'h400, 32'h999);
    check("dslot.in_dslot", 32'(in_dslot), 32'd1);
    check("dslot.err_before", 32'(dcti_err), 32'd0);
    expect_out("dcti", 32'h400, 32'h404, 1'b1, 1'b0);

    drive(1, 0, 0, 0, 0, 0, 0, 32'h404, 32'd0);
    check("dcti.in_dslot", 32'(in_dslot), 32'd0);
    check("dcti.err_set", 32'(dcti_err), 32'd1);
    expect_out("after_dcti", 32'h404, 32'h408, 1'b1, 1'b0);

    // Not taken, annulled -> ANNUL for one cycle.
    drive(1, 0, 0, 1, 0, 0, 1, 32'h200, 32'h500);
    expect_out("nt_annul", 32'h200, 32'h204, 1'b1, 1'b1);
    // In ANNUL a resolved taken branch must be ignored.
    drive(1, 0, 0, 1, 1, 0, 0, 32'h204, 32'h500);
    check("annul.in_dslot", 32'(in_dslot), 32'd0);
    expect_out("annul_ign", 32'h204, 32'h208, 1'b1, 1'b0);
    // Back in SEQ: same branch now takes effect.
    drive(1, 0, 0, 1, 1, 0, 1, 32'h700, 32'h800);
    check("annul_done.in_dslot", 32'(in_dslot), 32'd0);
    expect_out("cond_annul", 32'h700, 32'h800, 1'b1, 1'b0);

    // Stall inside the delay slot holds state and ignores the branch.
    drive(1, 1, 0, 1, 1, 0, 0, 32'h800, 32'h900);
    check("stall_ds.in_dslot", 32'(in_dslot), 32'd1);
    check("stall.PC_LE", 32'(PC_LE), 32'd0);
    check("stall.nPC_LE", 32'(nPC_LE), 32'd0);
    check("stall.squash", 32'(squash_IF), 32'd0);
    drive(1, 0, 0, 0, 0, 0, 0, 32'h800, 32'h0);
    check("stall_held.in_dslot", 32'(in_dslot), 32'd1);
    check("stall_held.err", 32'(dcti_err), 32'd1);
    expect_out("ds_exit", 32'h800, 32'h804, 1'b1, 1'b0);

    // Unconditional, annulled -> fetch target directly.
    drive(1, 0, 0, 1, 0, 1, 1, 32'h804, 32'h600);
    check("ds_exit.in_dslot", 32'(in_dslot), 32'd0);
    expect_out("ba_annul", 32'h600, 32'h604, 1'b1, 1'b1);

    // Not taken, not annulled -> sequential, stays SEQ.
    drive(1, 0, 0, 1, 0, 0, 0, 32'h604, 32'h700);
    check("ba_annul.in_dslot", 32'(in_dslot), 32'd0);
    expect_out("nt", 32'h604, 32'h608, 1'b1, 1'b0);

    // Trap beats stall.
    drive(1, 1, 1, 1, 1, 0, 0, 32'h300, 32'h400);
    expect_out("trap", 32'h80, 32'h84, 1'b1, 1'b1);
    // In TRAP state a branch is ignored.
    drive(1, 0, 0, 1, 1, 0, 0, 32'h84, 32'h400);
    expect_out("trap_ign", 32'h84, 32'h88, 1'b1, 1'b0);
    drive(1, 1, 0, 0, 0, 0, 0, 32'h88, 32'h0);
    check("trap_ign.in_dslot", 32'(in_dslot), 32'd0);
    check("stall_only.PC_LE", 32'(PC_LE), 32'd0);
    check("stall_only.nPC_LE", 32'(nPC_LE), 32'd0);

    // nPC wrap.
    drive(1, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 32'h0);
    expect_out("wrap", 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b0);

    // Reset mid-operation: enter DSLOT, then reset with a pending trap.
    drive(1, 0, 0, 1, 1, 0, 0, 32'h100, 32'h400);
    drive(0, 1, 1, 1, 1, 0, 0, 32'h400, 32'h0);
    check("midrst.in_dslot_before", 32'(in_dslot), 32'd1);
    expect_out("midrst", 32'h0, 32'h4, 1'b1, 1'b1);
    // First cycle after release behaves as SEQ: branch takes effect.
    drive(1, 0, 0, 1, 1, 0, 0, 32'h4, 32'h40);
    check("midrst.in_dslot_after", 32'(in_dslot), 32'd0);
    check("midrst.err_clr", 32'(dcti_err), 32'd0);
    expect_out("post_rst_br", 32'h4, 32'h40, 1'b1, 1'b0);
    drive(1, 0, 0, 0, 0, 0, 0, 32'h40, 32'h0);
    check("post_rst.in_dslot", 32'(in_dslot), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
